// File: rtl/ray_pkg.sv
// Shared types for the ray scheduler: 16.16 fixed point scalars, 3-vectors
// and the sequencer state encoding.
package ray_pkg;

    typedef logic signed [31:0] fix16_t;

    typedef struct packed {
        fix16_t x;
        fix16_t y;
        fix16_t z;
    } vec3_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DRAIN = 3'd4
    } sched_state_t;

    localparam fix16_t FIX_ONE = 32'sh0001_0000;

    // Signed pixel offset to 16.16; arithmetic shift keeps the sign.
    function automatic fix16_t offset_to_fix(input fix16_t offset, input int unsigned shift);
        return offset <<< shift;
    endfunction

endpackage

// File: rtl/pixel_counter.sv
// Raster-order pixel counters with synchronous clear and advance.
// The next-count outputs let the parent register values derived from the
// coming pixel on the same edge the counters move.
module pixel_counter #(
    parameter int H_RES = 320,
    parameter int V_RES = 180,
    parameter int HW    = $clog2(H_RES),
    parameter int VW    = $clog2(V_RES)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          clear,
    input  logic          advance,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic [HW-1:0] h_nxt,
    output logic [VW-1:0] v_nxt,
    output logic          last
);

    localparam logic [HW-1:0] H_MAX = HW'(H_RES - 1);
    localparam logic [VW-1:0] V_MAX = VW'(V_RES - 1);

    always_comb begin
        h_nxt = hcount;
        v_nxt = vcount;
        if (clear) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (advance) begin
            if (hcount == H_MAX) begin
                h_nxt = '0;
                v_nxt = (vcount == V_MAX) ? '0 : vcount + VW'(1);
            end else begin
                h_nxt = hcount + HW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hcount <= '0;
            vcount <= '0;
        end else begin
            hcount <= h_nxt;
            vcount <= v_nxt;
        end
    end

    assign last = (hcount == H_MAX) && (vcount == V_MAX);

endmodule

// File: rtl/ray_scheduler.sv
// Frame sweep sequencer: issues one camera-space vector per pixel to ray_gen
// and forwards each normalised direction to the tracer over valid/ready.
//
//   state | meaning
//   IDLE  | waiting for frame_start_in
//   ISSUE | rg_start_out high for one cycle, operands already registered
//   WAIT  | ray_gen busy; first cycle ignores a stale done
//   OUT   | ray presented downstream until accepted
//   DRAIN | aborted while ray_gen busy; wait for its done then finish
module ray_scheduler
    import ray_pkg::*;
#(
    parameter int          H_RES     = 320,
    parameter int          V_RES     = 180,
    parameter int          PIX_SHIFT = 8,
    parameter logic [31:0] FOCAL     = FIX_ONE,
    localparam int         HW        = $clog2(H_RES),
    localparam int         VW        = $clog2(V_RES)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          frame_start_in,
    input  logic          frame_abort_in,
    output logic          frame_busy_out,
    output logic          frame_done_out,
    output logic          rg_start_out,
    output logic [31:0]   rg_x_out,
    output logic [31:0]   rg_y_out,
    output logic [31:0]   rg_z_out,
    input  logic          rg_done_in,
    input  logic [31:0]   rg_dir_x_in,
    input  logic [31:0]   rg_dir_y_in,
    input  logic [31:0]   rg_dir_z_in,
    output logic          ray_valid_out,
    input  logic          ray_ready_in,
    output logic [31:0]   ray_dir_x_out,
    output logic [31:0]   ray_dir_y_out,
    output logic [31:0]   ray_dir_z_out,
    output logic [HW-1:0] ray_hcount_out,
    output logic [VW-1:0] ray_vcount_out,
    output logic          ray_last_out
);

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_ISSUE = S_ISSUE;
    localparam logic [2:0] ST_WAIT  = S_WAIT;
    localparam logic [2:0] ST_OUT   = S_OUT;
    localparam logic [2:0] ST_DRAIN = S_DRAIN;

    localparam fix16_t H_HALF = fix16_t'(H_RES / 2);
    localparam fix16_t V_HALF = fix16_t'(V_RES / 2);

    logic [2:0]    state, state_nxt;
    logic          cnt_clear, cnt_adv, capture, done_nxt;
    logic          wait_first, rg_ok, accept;
    logic [HW-1:0] hcount, h_nxt;
    logic [VW-1:0] vcount, v_nxt;
    logic          last;
    vec3_t         op_q, op_nxt, dir_q;

    pixel_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .HW    (HW),
        .VW    (VW)
    ) u_pixel_counter (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .hcount  (hcount),
        .vcount  (vcount),
        .h_nxt   (h_nxt),
        .v_nxt   (v_nxt),
        .last    (last)
    );

    // Operands come from the next counts so they are valid in the ISSUE cycle.
    assign op_nxt = {offset_to_fix(fix16_t'({1'b0, h_nxt}) - H_HALF, PIX_SHIFT),
                     offset_to_fix(V_HALF - fix16_t'({1'b0, v_nxt}), PIX_SHIFT),
                     fix16_t'(FOCAL)};

    assign rg_ok  = rg_done_in && !wait_first;
    assign accept = ray_valid_out && ray_ready_in;

    always_comb begin
        state_nxt = state;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        capture   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start_in) begin
                    state_nxt = ST_ISSUE;
                    cnt_clear = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (frame_abort_in) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An abort that coincides with done has nothing left to drain.
                if (frame_abort_in) begin
                    if (rg_ok) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end else if (rg_ok) begin
                    state_nxt = ST_OUT;
                    capture   = 1'b1;
                end
            end
            ST_OUT: begin
                if (frame_abort_in) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else if (accept) begin
                    if (last) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_ISSUE;
                        cnt_adv   = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (rg_done_in) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= ST_IDLE;
            frame_busy_out <= 1'b0;
            frame_done_out <= 1'b0;
            rg_start_out   <= 1'b0;
            ray_valid_out  <= 1'b0;
            wait_first     <= 1'b0;
            op_q           <= '0;
            dir_q          <= '0;
        end else begin
            state          <= state_nxt;
            frame_busy_out <= (state_nxt != ST_IDLE);
            frame_done_out <= done_nxt;
            rg_start_out   <= (state_nxt == ST_ISSUE);
            ray_valid_out  <= (state_nxt == ST_OUT);
            wait_first     <= (state == ST_ISSUE);
            if (state_nxt == ST_ISSUE) begin
                op_q <= op_nxt;
            end
            if (capture) begin
                dir_q <= {rg_dir_x_in, rg_dir_y_in, rg_dir_z_in};
            end
        end
    end

    assign rg_x_out       = op_q.x;
    assign rg_y_out       = op_q.y;
    assign rg_z_out       = op_q.z;
    assign ray_dir_x_out  = dir_q.x;
    assign ray_dir_y_out  = dir_q.y;
    assign ray_dir_z_out  = dir_q.z;
    assign ray_hcount_out = hcount;
    assign ray_vcount_out = vcount;
    assign ray_last_out   = last;

endmodule

// File: tb/tb_ray_scheduler.sv
// Self-checking bench for ray_scheduler on a 4x2 screen with an echoing
// ray_gen stub of latency 5.
module tb_ray_scheduler;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int LAT   = 5;
    localparam int NRAYS = H * V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic frame_abort = 1'b0;
    logic ray_ready = 1'b1;
    logic frame_busy, frame_done, rg_start, rg_done, ray_valid, ray_last;
    logic [31:0] rg_x, rg_y, rg_z, rg_dir_x, rg_dir_y, rg_dir_z;
    logic [31:0] ray_dir_x, ray_dir_y, ray_dir_z;
    logic [$clog2(H)-1:0] ray_h;
    logic [$clog2(V)-1:0] ray_v;

    int checks = 0;
    int errors = 0;
    int overlaps = 0;
    int unstable = 0;

    always #5 clk = ~clk;

    ray_scheduler #(
        .H_RES     (H),
        .V_RES     (V),
        .PIX_SHIFT (8),
        .FOCAL     (32'h0001_0000)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .frame_start_in (frame_start),
        .frame_abort_in (frame_abort),
        .frame_busy_out (frame_busy),
        .frame_done_out (frame_done),
        .rg_start_out   (rg_start),
        .rg_x_out       (rg_x),
        .rg_y_out       (rg_y),
        .rg_z_out       (rg_z),
        .rg_done_in     (rg_done),
        .rg_dir_x_in    (rg_dir_x),
        .rg_dir_y_in    (rg_dir_y),
        .rg_dir_z_in    (rg_dir_z),
        .ray_valid_out  (ray_valid),
        .ray_ready_in   (ray_ready),
        .ray_dir_x_out  (ray_dir_x),
        .ray_dir_y_out  (ray_dir_y),
        .ray_dir_z_out  (ray_dir_z),
        .ray_hcount_out (ray_h),
        .ray_vcount_out (ray_v),
        .ray_last_out   (ray_last)
    );

    // ray_gen stub: done appears LAT cycles after the start is sampled, echoing operands.
    int stub_cnt;
    logic [31:0] sx, sy, sz;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= 0;
            rg_done  <= 1'b0;
            sx <= '0;
            sy <= '0;
            sz <= '0;
        end else begin
            rg_done <= 1'b0;
            if (rg_start) begin
                stub_cnt <= LAT;
                sx <= rg_x;
                sy <= rg_y;
                sz <= rg_z;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) rg_done <= 1'b1;
            end
        end
    end
    assign rg_dir_x = sx;
    assign rg_dir_y = sy;
    assign rg_dir_z = sz;

    always @(posedge clk) begin
        if (rst_n && rg_start && stub_cnt != 0) overlaps++;
        if (rst_n && !rg_start && stub_cnt != 0 && {rg_x, rg_y, rg_z} !== {sx, sy, sz}) unstable++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected ray i from the raster order and the pixel-to-vector rule.
    function automatic logic [127:0] model_ray(input int i);
        int h = i % H;
        int v = i / H;
        logic [31:0] x = 32'((h - H / 2) * 256);
        logic [31:0] y = 32'((V / 2 - v) * 256);
        logic [31:0] z = 32'h0001_0000;
        return {x, y, z, 16'(h), 15'(v), (i == NRAYS - 1)};
    endfunction

    function automatic logic [127:0] cur_ray();
        return {ray_dir_x, ray_dir_y, ray_dir_z, 16'(ray_h), 15'(ray_v), ray_last};
    endfunction

    // mode 0: ready high, 1: stall ray 2 for 10 cycles, 2: random ready
    task automatic run_frame(input int mode, input bit abort_with_start, input bit extra_start,
                             input int exp_len, input string name);
        int rays = 0, dones = 0, done_cyc = 0, stall = 0, bad_start = 0, n = 0;
        bit pending = 0;
        logic [127:0] snap = '0;
        @(negedge clk);
        frame_start = 1'b1;
        frame_abort = abort_with_start;
        ray_ready   = 1'b1;
        while (n < 600 && (dones == 0 || n < done_cyc + 4)) begin
            @(negedge clk);
            n++;
            frame_start = extra_start && (n == 20 || n == 40);
            frame_abort = 1'b0;
            case (mode)
                1:       ray_ready = !(rays == 2 && stall < 10);
                2:       ray_ready = 1'($urandom_range(0, 1));
                default: ray_ready = 1'b1;
            endcase
            if (ray_valid) begin
                if (rg_start) bad_start++;
                if (pending) check($sformatf("%s_hold", name), cur_ray(), snap);
                if (ray_ready) begin
                    check($sformatf("%s_ray%0d", name, rays), cur_ray(), model_ray(rays));
                    rays++;
                    pending = 0;
                end else begin
                    snap = cur_ray();
                    pending = 1;
                    stall++;
                end
            end
            if (frame_done) begin
                dones++;
                if (dones == 1) done_cyc = n;
            end
        end
        check($sformatf("%s_nrays", name), 128'(rays), 128'(NRAYS));
        check($sformatf("%s_ndone", name), 128'(dones), 128'(1));
        check($sformatf("%s_start_in_out", name), 128'(bad_start), 128'(0));
        check($sformatf("%s_busy_end", name), 128'(frame_busy), 128'(0));
        if (exp_len > 0) check($sformatf("%s_len", name), 128'(done_cyc), 128'(exp_len));
    endtask

    int n, late_start, dones, done_cyc, stub_done_cyc, valids;
    logic busy_mid;
    bit found;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", {ray_valid, frame_busy, frame_done, rg_start, ray_last}, '0);
        check("rst_ops", {rg_x, rg_y, rg_z}, '0);
        check("rst_dir", {ray_dir_x, ray_dir_y, ray_dir_z}, '0);
        check("rst_cnt", {ray_h, ray_v}, '0);
        rst_n = 1'b1;

        run_frame(0, 1'b0, 1'b0, NRAYS * (LAT + 3) + 1, "basic");
        run_frame(1, 1'b0, 1'b1, NRAYS * (LAT + 3) + 1 + 10, "stall");
        run_frame(2, 1'b0, 1'b0, 0, "rand_a");
        run_frame(2, 1'b0, 1'b1, 0, "rand_b");
        run_frame(0, 1'b1, 1'b0, NRAYS * (LAT + 3) + 1, "start_abort");

        // Abort while ray_gen is busy
        late_start = 0; dones = 0; done_cyc = 0; stub_done_cyc = 0; valids = 0; busy_mid = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            frame_start = 1'b0;
            frame_abort = (n == 3);
            if (rg_start && n > 1) late_start++;
            if (rg_done && stub_done_cyc == 0) stub_done_cyc = n;
            if (frame_done) begin
                dones++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (ray_valid) valids++;
            if (n == 5) busy_mid = frame_busy;
        end
        frame_abort = 1'b0;
        check("abort_late_start", 128'(late_start), 128'(0));
        check("abort_ndone", 128'(dones), 128'(1));
        check("abort_done_cyc", 128'(done_cyc), 128'(1 + LAT + 2));
        check("abort_done_after_stub", 128'(done_cyc), 128'(stub_done_cyc + 1));
        check("abort_valids", 128'(valids), 128'(0));
        check("abort_busy_mid", 128'(busy_mid), 128'(1));
        check("abort_busy_end", 128'(frame_busy), 128'(0));

        // Asynchronous reset while a ray is presented
        @(negedge clk);
        frame_start = 1'b1;
        ray_ready = 1'b0;
        found = 0;
        n = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            frame_start = 1'b0;
            if (ray_valid) found = 1;
        end
        check("rst_mid_reached_out", 128'(found), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {ray_valid, frame_busy, rg_start, frame_done}, '0);
        check("rst_mid_dir", {ray_dir_x, ray_dir_y, ray_dir_z}, '0);
        check("rst_mid_ops", {rg_x, rg_y, rg_z}, '0);
        check("rst_mid_cnt", {ray_h, ray_v}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ray_ready = 1'b1;
        run_frame(0, 1'b0, 1'b0, NRAYS * (LAT + 3) + 1, "post_rst");

        check("rg_overlap", 128'(overlaps), 128'(0));
        check("rg_operand_stable", 128'(unstable), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ray_scheduler.md
# ray_scheduler

Frame-level sequencer for the `ray_gen` direction-normalisation unit. On a frame request it sweeps every screen pixel in raster order and builds the un-normalised camera-space vector for each pixel in 16.16 fixed point. It issues that vector to `ray_gen` over the start/done handshake, captures the normalised direction, and presents it with pixel coordinates to the downstream tracer over a valid/ready interface. It sits between the frame controller and the ray-march/trace pipeline and is the only master of `ray_gen`.

## Interface
Parameters:
- `H_RES`, 320, pixels per line
- `V_RES`, 180, lines per frame
- `PIX_SHIFT`, 8, left shift turning a pixel offset into 16.16 (step = 1/256)
- `FOCAL`, 32'h0001_0000, constant z component (1.0 in 16.16)

Ports:
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset, asynchronous, active-low
- `frame_start_in`  in  1  request one frame sweep; sampled in IDLE only
- `frame_abort_in`  in  1  abandon current frame
- `frame_busy_out`  out  1  high from accept of start until return to IDLE
- `frame_done_out`  out  1  one-cycle pulse after the last ray is accepted, or after an abort completes
- `rg_start_out`  out  1  one-cycle start pulse to `ray_gen`
- `rg_x_out`, `rg_y_out`, `rg_z_out`  out  32 each  signed 16.16 operands, held stable from start until done
- `rg_done_in`  in  1  `ray_gen` result valid
- `rg_dir_x_in`, `rg_dir_y_in`, `rg_dir_z_in`  in  32 each  normalised direction
- `ray_valid_out`  out  1  output ray valid
- `ray_ready_in`  in  1  downstream accept
- `ray_dir_x_out`, `ray_dir_y_out`, `ray_dir_z_out`  out  32 each  captured direction
- `ray_hcount_out`  out  $clog2(H_RES)  pixel column
- `ray_vcount_out`  out  $clog2(V_RES)  pixel row
- `ray_last_out`  out  1  marks the final pixel of the frame

## Operation
- States: IDLE, ISSUE, WAIT, OUT, DRAIN.
- IDLE, when `frame_start_in`=1: clear counters to (0,0), set busy, go to ISSUE.
- ISSUE lasts one cycle. Drive `rg_start_out`=1 and register the operands:
  - x = sign-extended (hcount − H_RES/2) <<< PIX_SHIFT
  - y = (V_RES/2 − vcount) <<< PIX_SHIFT
  - z = FOCAL
  - Then go to WAIT.
- WAIT: on the first cycle with `rg_done_in`=1, latch `rg_dir_*_in` into the output registers and go to OUT. Contract: `ray_gen` deasserts done no later than the cycle after start, so done is ignored on the cycle WAIT is entered.
- OUT:
  - `ray_valid_out`=1. Data, counts and last stay stable until `ray_valid_out && ray_ready_in`.
  - On accept: if last pixel, pulse `frame_done_out` and go to IDLE. Otherwise advance hcount; on hcount=H_RES−1 wrap it to 0 and increment vcount. Then go to ISSUE.
- `ray_last_out` = (hcount==H_RES−1 && vcount==V_RES−1).
- Abort:
  - In ISSUE or OUT: go to IDLE next cycle, drop valid, pulse done.
  - In WAIT: go to DRAIN, wait for `rg_done_in`, discard the result, pulse done, go to IDLE. `ray_gen` is never restarted mid-computation.
  - In IDLE: ignored.
- Start and abort asserted together in IDLE: start wins and abort is ignored.
- `frame_start_in` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, all outputs 0, counters 0, operand registers 0.
- Latency:
  - Frame start to first `rg_start_out`: 1 cycle.
  - Done capture to `ray_valid_out`: 1 cycle.
  - Accept to next `rg_start_out`: 1 cycle.
- Per-ray period with ready held high: L_rg + 3 cycles.
- Each `rg_start_out` pulse is exactly 1 cycle wide; there is at most one outstanding `ray_gen` operation.
- `frame_done_out` asserts on the cycle after the final accept.
- Asynchronous reset mid-frame forces IDLE immediately and deasserts valid and start.

## Structure
- Package `ray_pkg` holds:
  - `fix16_t` (logic signed [31:0])
  - `vec3_t` packed struct {x, y, z}
  - `sched_state_t` enum
  - `FIX_ONE` = 32'h0001_0000
- Sub-module `pixel_counter`: raster h/v counters with clear, advance, wrap and last flag.

## Test plan
Bench setup: H_RES=4, V_RES=2, PIX_SHIFT=8, with a stub `ray_gen` of latency 5 that echoes its inputs.
- Start, ready tied high:
  - Exactly 8 rays in raster order.
  - First ray: x=0xFFFF_FE00, y=0x0000_0100, z=0x0001_0000.
  - Last ray: (3,1) with x=0x100, y=0, `ray_last_out`=1.
  - `frame_done_out` pulses once; frame length = 8×(5+3)+1 cycles.
- Backpressure, ready low for 10 cycles on ray 2: data held stable and no new `rg_start_out` during the stall.
- Abort during WAIT: no further start; done pulses only after the stub's done arrives; busy=0 afterwards.
- Start and abort asserted together in IDLE: the frame starts normally.
- Reset asserted low mid-OUT: outputs go to 0 asynchronously; a new start after release sweeps from (0,0).
- Start pulse while busy: ignored, exactly 8 rays still delivered.
